// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift execution unit.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_RSV = 2'b11
    } shift_op_t;

    localparam int unsigned MAX_W = 64;

    // Reverses the low w bits of v; upper bits of the return value are zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] r;
        logic [5:0]       src;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                src       = 6'(w - 1 - i);
                r[i[5:0]] = v[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Issue-side and writeback-side valid/ready bundle of the shift unit.
interface shift_pipe_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned TAGW = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [N-1:0]         in_a;
    logic [$clog2(N)-1:0] in_shamt;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_result;
    logic [TAGW-1:0]      out_tag;
    logic                 out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
endinterface

// File: rtl/shift_stage_reg.sv
// Valid/data pipeline register; flush clears valid only, data is loaded only with a valid entry.
module shift_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= d_valid;
            if (d_valid) q <= d;
        end
    end
endmodule

// File: rtl/srl.sv
// Combinational logical right shifter.
module srl #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         result
);
    assign result = data >> shamt;
endmodule

// File: rtl/shift_pipe.sv
// Two-stage elastic SLL/SRL/SRA unit built from logical-right shifters only.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    shift_pipe_if.slave bus
);
    localparam int unsigned SW  = $clog2(N);
    localparam int unsigned S1W = 2 + SW + TAGW + 1 + N;
    localparam int unsigned S2W = 1 + TAGW + N;

    logic           s1_valid, s2_valid, s2_free;
    logic [S1W-1:0] s1_d, s1_q;
    logic [S2W-1:0] s2_d, s2_q;

    logic [N-1:0]    pre_data;
    logic            pre_sign;
    logic [1:0]      s1_op;
    logic [SW-1:0]   s1_shamt;
    logic [TAGW-1:0] s1_tag;
    logic            s1_sign;
    logic [N-1:0]    s1_data;

    logic [N-1:0] ones, u0_y, u1_y, fill, result;
    logic         illegal;

    assign s2_free      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid || s2_free);

    // SLL is done as reverse -> SRL -> reverse, so the operand is pre-reversed here.
    always_comb begin
        pre_data = bus.in_a;
        pre_sign = 1'b0;
        if (shift_op_t'(bus.in_op) == SHIFT_SLL) pre_data = N'(bitrev(MAX_W'(bus.in_a), N));
        if (shift_op_t'(bus.in_op) == SHIFT_SRA) pre_sign = bus.in_a[N-1];
    end

    assign s1_d = {bus.in_op, bus.in_shamt, bus.in_tag, pre_sign, pre_data};
    assign {s1_op, s1_shamt, s1_tag, s1_sign, s1_data} = s1_q;

    shift_stage_reg #(.W(S1W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (bus.in_ready),
        .d_valid (bus.in_valid),
        .d       (s1_d),
        .valid   (s1_valid),
        .q       (s1_q)
    );

    assign ones = '1;

    srl #(.N(N)) u0 (
        .data   (s1_data),
        .shamt  (s1_shamt),
        .result (u0_y)
    );

    srl #(.N(N)) u1 (
        .data   (ones),
        .shamt  (s1_shamt),
        .result (u1_y)
    );

    always_comb begin
        fill    = s1_sign ? ~u1_y : '0;
        result  = '0;
        illegal = 1'b0;
        case (shift_op_t'(s1_op))
            SHIFT_SLL: result = N'(bitrev(MAX_W'(u0_y), N));
            SHIFT_SRL: result = u0_y;
            SHIFT_SRA: result = u0_y | fill;
            SHIFT_RSV: illegal = 1'b1;
        endcase
    end

    assign s2_d = {illegal, s1_tag, result};

    shift_stage_reg #(.W(S2W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (s2_free),
        .d_valid (s1_valid),
        .d       (s2_d),
        .valid   (s2_valid),
        .q       (s2_q)
    );

    assign bus.out_valid = s2_valid;
    assign {bus.out_illegal, bus.out_tag, bus.out_result} = s2_q;
endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (N=32, TAGW=5).
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [37:0] exp_q[$];
    logic [37:0] e;

    shift_pipe_if #(.N(32), .TAGW(5)) bus ();

    shift_pipe #(.N(32), .TAGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {illegal, tag, result}
    function automatic logic [37:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [4:0] sh, input logic [4:0] tag);
        logic [31:0] r;
        logic        ill;
        ill = 1'b0;
        case (op)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = 32'($signed(a) >>> sh);
            default: begin r = '0; ill = 1'b1; end
        endcase
        return {ill, tag, r};
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] sh, input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op with out_ready=1; expects the result exactly two edges after acceptance.
    task automatic send_one(input string nm, input logic [1:0] op, input logic [31:0] a,
                            input logic [4:0] sh, input logic [4:0] tag,
                            input logic [31:0] exp_r, input logic exp_ill);
        bus.out_ready = 1'b1;
        drive(1'b1, op, a, sh, tag);
        #1 check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
        check({nm, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
        tick();
        check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({nm, "_result"}, 64'(bus.out_result), 64'(exp_r));
        check({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
        check({nm, "_illegal"}, 64'(bus.out_illegal), 64'(exp_ill));
        tick();
        check({nm, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Directed single ops
        send_one("sll31", 2'b00, 32'h0000_0001, 5'd31, 5'h03, 32'h8000_0000, 1'b0);
        send_one("srl31", 2'b01, 32'h8000_0000, 5'd31, 5'h07, 32'h0000_0001, 1'b0);
        send_one("sra4", 2'b10, 32'h8000_0000, 5'd4, 5'h11, 32'hF800_0000, 1'b0);
        send_one("sra31", 2'b10, 32'h8765_4321, 5'd31, 5'h12, 32'hFFFF_FFFF, 1'b0);
        send_one("sra0", 2'b10, 32'h8765_4321, 5'd0, 5'h13, 32'h8765_4321, 1'b0);
        send_one("sll0", 2'b00, 32'hA5A5_0F0F, 5'd0, 5'h14, 32'hA5A5_0F0F, 1'b0);
        send_one("sll5", 2'b00, 32'h1234_5678, 5'd5, 5'h15, 32'h468A_CF00, 1'b0);
        send_one("sra_pos", 2'b10, 32'h7000_0000, 5'd3, 5'h16, 32'h0E00_0000, 1'b0);
        send_one("illegal", 2'b11, 32'hFFFF_FFFF, 5'd5, 5'h1A, 32'h0000_0000, 1'b1);
        send_one("after_ill", 2'b01, 32'hFFFF_FFFF, 5'd8, 5'h1B, 32'h00FF_FFFF, 1'b0);

        // Back-to-back stream of 8 random ops
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                logic [1:0]  op;
                logic [31:0] a;
                logic [4:0]  sh;
                op = 2'($urandom_range(0, 2));
                a  = $urandom;
                sh = 5'($urandom_range(0, 31));
                drive(1'b1, op, a, sh, 5'(k + 1));
                exp_q.push_back(model(op, a, sh, 5'(k + 1)));
                #1 check($sformatf("stream_in_ready_%0d", k), 64'(bus.in_ready), 64'd1);
            end else begin
                drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
            end
            tick();
            check($sformatf("stream_valid_%0d", k), 64'(bus.out_valid), 64'((k >= 1) && (k <= 8)));
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("stream_out_%0d", k),
                      64'({bus.out_illegal, bus.out_tag, bus.out_result}), 64'(e));
            end
        end
        tick();
        check("stream_idle", 64'(bus.out_valid), 64'd0);

        // Backpressure: out_ready low for 5 cycles, 3 ops offered
        exp_q.delete();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) bus.out_ready = 1'b1;
            if (k == 0) begin
                drive(1'b1, 2'b01, 32'hDEAD_BEEF, 5'd4, 5'h05);
                exp_q.push_back(model(2'b01, 32'hDEAD_BEEF, 5'd4, 5'h05));
            end else if (k == 1) begin
                drive(1'b1, 2'b00, 32'h0000_00FF, 5'd12, 5'h06);
                exp_q.push_back(model(2'b00, 32'h0000_00FF, 5'd12, 5'h06));
            end else if (k == 2) begin
                drive(1'b1, 2'b10, 32'hC000_1234, 5'd8, 5'h07);
                exp_q.push_back(model(2'b10, 32'hC000_1234, 5'd8, 5'h07));
            end else if (k >= 6) begin
                drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
            end
            #1;
            if (k <= 5) check($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready), 64'(k < 2 || k == 5));
            tick();
            if (k >= 1 && k <= 4) begin
                check($sformatf("bp_hold_valid_%0d", k), 64'(bus.out_valid), 64'd1);
                check($sformatf("bp_hold_out_%0d", k),
                      64'({bus.out_illegal, bus.out_tag, bus.out_result}), 64'(exp_q[0]));
            end else if (k >= 5 && k <= 6) begin
                void'(exp_q.pop_front());
                check($sformatf("bp_drain_valid_%0d", k), 64'(bus.out_valid), 64'd1);
                check($sformatf("bp_drain_out_%0d", k),
                      64'({bus.out_illegal, bus.out_tag, bus.out_result}), 64'(exp_q[0]));
            end else if (k == 7) begin
                check("bp_empty", 64'(bus.out_valid), 64'd0);
            end
        end

        // Flush with both stages full
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h1111_1111, 5'd1, 5'h08);
        tick();
        drive(1'b1, 2'b01, 32'h2222_2222, 5'd1, 5'h09);
        tick();
        drive(1'b1, 2'b01, 32'h3333_3333, 5'd1, 5'h0A);
        check("fl_full_valid", 64'(bus.out_valid), 64'd1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1 check("fl_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
        check("fl_valid_next", 64'(bus.out_valid), 64'd0);
        tick();
        check("fl_s1_cleared", 64'(bus.out_valid), 64'd0);
        send_one("post_flush", 2'b10, 32'hF000_000F, 5'd2, 5'h0B, 32'hFC00_0003, 1'b0);

        // Asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd30, 5'h1C);
        tick();
        drive(1'b1, 2'b10, 32'hFFFF_0000, 5'd16, 5'h1D);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'h0, 5'h0);
        check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_result", 64'(bus.out_result), 64'd0);
        check("ar_tag", 64'(bus.out_tag), 64'd0);
        check("ar_illegal", 64'(bus.out_illegal), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("ar_in_ready", 64'(bus.in_ready), 64'd1);
        check("ar_idle", 64'(bus.out_valid), 64'd0);
        send_one("post_rst", 2'b01, 32'h00F0_0000, 5'd20, 5'h02, 32'h0000_000F, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
